// File: rtl/pla_x1dn_pkg.sv
// Shared types for the x1dn PLA vector loader: PLA geometry, loader FSM
// states and the tagged result record.
package pla_x1dn_pkg;

    localparam int unsigned NIN   = 27;
    localparam int unsigned NOUT  = 6;
    localparam int unsigned TAG_W = 8;

    // ST_ prefix keeps the state names clear of the SETTLE parameter
    typedef enum logic [1:0] {
        ST_SHIFT  = 2'd0,
        ST_SETTLE = 2'd1,
        ST_EMIT   = 2'd2
    } state_e;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [NOUT-1:0]  z;
    } result_t;

endpackage

// File: rtl/pla_x1dn_vec_loader.sv
// Bit-serial feeder and result capture for the x1dn PLA.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   s_valid/s_ready     serial beat handshake; s_data is one PLA input bit,
//   s_data/s_first      x00 first, s_first marks the x00 beat
//   x_out               PLA inputs, changes only when a full vector lands
//   z_in                PLA outputs, sampled SETTLE cycles after x_out updates
//   m_valid/m_ready     result handshake; m_data = {tag, z}
//   err_cnt             saturating framing error count
module pla_x1dn_vec_loader #(
    parameter int unsigned NIN    = 27,
    parameter int unsigned NOUT   = 6,
    parameter int unsigned SETTLE = 2,
    parameter int unsigned TAG_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  s_data,
    input  logic                  s_first,
    output logic [NIN-1:0]        x_out,
    input  logic [NOUT-1:0]       z_in,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [TAG_W+NOUT-1:0] m_data,
    output logic [7:0]            err_cnt
);
    import pla_x1dn_pkg::*;

    // Geometry is fixed by the PLA and by the packaged result record
    if (NIN != pla_x1dn_pkg::NIN) begin : g_bad_nin
        $error("pla_x1dn_vec_loader: NIN must be 27");
    end
    if (NOUT != pla_x1dn_pkg::NOUT) begin : g_bad_nout
        $error("pla_x1dn_vec_loader: NOUT must match pla_x1dn_pkg::NOUT");
    end
    if (TAG_W != pla_x1dn_pkg::TAG_W) begin : g_bad_tag
        $error("pla_x1dn_vec_loader: TAG_W must match pla_x1dn_pkg::TAG_W");
    end
    if (SETTLE < 1) begin : g_bad_settle
        $error("pla_x1dn_vec_loader: SETTLE must be at least 1");
    end

    localparam int unsigned CNT_W   = $clog2(NIN);
    localparam int unsigned SET_W   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int unsigned ERR_W   = 8;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NIN - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    state_e             state_q,      state_d;
    logic [CNT_W-1:0]   bit_cnt_q,    bit_cnt_d;
    logic [SET_W-1:0]   settle_cnt_q, settle_cnt_d;
    logic [NIN-1:0]     shadow_q,     shadow_d;
    logic [NIN-1:0]     x_out_q,      x_out_d;
    result_t            m_data_q,     m_data_d;
    logic               m_valid_q,    m_valid_d;
    logic               s_ready_q,    s_ready_d;
    logic [TAG_W-1:0]   tag_q,        tag_d;
    logic [ERR_W-1:0]   err_cnt_q,    err_cnt_d;
    logic               err_inc;

    // Next-state and output computation
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        settle_cnt_d = settle_cnt_q;
        shadow_d     = shadow_q;
        x_out_d      = x_out_q;
        m_data_d     = m_data_q;
        m_valid_d    = m_valid_q;
        tag_d        = tag_q;
        err_cnt_d    = err_cnt_q;
        err_inc      = 1'b0;

        case (state_q)
            ST_SHIFT: begin
                if (s_valid && s_ready_q) begin
                    if (s_first) begin
                        // A first marker mid-vector restarts the vector on this beat
                        err_inc     = (bit_cnt_q != '0);
                        shadow_d[0] = s_data;
                        bit_cnt_d   = CNT_W'(1);
                    end else if (bit_cnt_q == '0) begin
                        err_inc = 1'b1;
                    end else if (bit_cnt_q == LAST_BIT) begin
                        // Whole vector lands on the PLA in one edge
                        x_out_d          = shadow_q;
                        x_out_d[NIN-1]   = s_data;
                        bit_cnt_d        = '0;
                        settle_cnt_d     = SET_W'(SETTLE - 1);
                        state_d          = ST_SETTLE;
                    end else begin
                        shadow_d[bit_cnt_q] = s_data;
                        bit_cnt_d           = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q == '0) begin
                    m_data_d.tag = tag_q;
                    m_data_d.z   = z_in;
                    m_valid_d    = 1'b1;
                    state_d      = ST_EMIT;
                end else begin
                    settle_cnt_d = settle_cnt_q - SET_W'(1);
                end
            end
            ST_EMIT: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    tag_d     = tag_q + TAG_W'(1);
                    state_d   = ST_SHIFT;
                end
            end
            default: state_d = ST_SHIFT;
        endcase

        if (err_inc && (err_cnt_q != ERR_MAX)) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end

        s_ready_d = (state_d == ST_SHIFT);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_SHIFT;
            bit_cnt_q    <= '0;
            settle_cnt_q <= '0;
            shadow_q     <= '0;
            x_out_q      <= '0;
            m_data_q     <= '0;
            m_valid_q    <= 1'b0;
            s_ready_q    <= 1'b1;
            tag_q        <= '0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            shadow_q     <= shadow_d;
            x_out_q      <= x_out_d;
            m_data_q     <= m_data_d;
            m_valid_q    <= m_valid_d;
            s_ready_q    <= s_ready_d;
            tag_q        <= tag_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign s_ready = s_ready_q;
    assign x_out   = x_out_q;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_pla_x1dn_vec_loader.sv
// Self-checking bench for pla_x1dn_vec_loader. A stand-in PLA function is
// driven on z_in; expected vectors, tags and error counts come from a
// stream-level reference model kept here.
module tb_pla_x1dn_vec_loader;
    localparam int unsigned NIN    = 27;
    localparam int unsigned NOUT   = 6;
    localparam int unsigned SETTLE = 2;
    localparam int unsigned TAG_W  = 8;

    typedef struct packed { logic d; logic f; } beat_t;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic                  s_valid = 1'b0;
    logic                  s_ready;
    logic                  s_data = 1'b0;
    logic                  s_first = 1'b0;
    logic [NIN-1:0]        x_out;
    logic [NOUT-1:0]       z_in;
    logic                  m_valid;
    logic                  m_ready;
    logic [TAG_W+NOUT-1:0] m_data;
    logic [7:0]            err_cnt;

    logic [NOUT-1:0] z_drv = '0;
    bit              z_from_x = 1'b0;
    bit              mon_en = 1'b0;
    bit              rand_ready = 1'b0;
    logic            m_ready_drv = 1'b0;
    logic            m_ready_rand = 1'b0;

    logic [TAG_W+NOUT-1:0] got_q[$];
    beat_t                 stim_q[$];
    logic [NIN-1:0]        exp_vec_q[$];

    int n_chk = 0;
    int n_pass = 0;
    int exp_err = 0;
    int exp_tag = 0;

    always #5 clk = ~clk;

    // Stand-in PLA: fold the 27 inputs into 6 bits
    function automatic logic [NOUT-1:0] pla_model(input logic [NIN-1:0] x);
        logic [29:0] p;
        p = {3'b000, x};
        return p[5:0] ^ p[11:6] ^ p[17:12] ^ p[23:18] ^ p[29:24];
    endfunction

    assign z_in    = z_from_x ? pla_model(x_out) : z_drv;
    assign m_ready = mon_en ? m_ready_rand : m_ready_drv;

    pla_x1dn_vec_loader #(
        .NIN(NIN), .NOUT(NOUT), .SETTLE(SETTLE), .TAG_W(TAG_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_first(s_first),
        .x_out(x_out), .z_in(z_in),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .err_cnt(err_cnt)
    );

    // Result monitor: choose m_ready, then record results whose handshake
    // completes at the coming rising edge
    always @(negedge clk) begin
        if (mon_en) begin
            m_ready_rand = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_valid && m_ready_rand) got_q.push_back(m_data);
        end
    end

    task automatic send_beat(input logic d, input logic f);
        int n;
        n = 0;
        s_valid = 1'b1; s_data = d; s_first = f;
        while (s_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_chk++;
            $display("FAIL beat_accept: s_ready=%b required 1 within 200 cycles", s_ready);
        end
        @(negedge clk);
        s_valid = 1'b0; s_first = 1'b0;
    endtask

    task automatic send_bits(input logic [NIN-1:0] v, input int nbits);
        for (int i = 0; i < nbits; i++) send_beat(v[i], i == 0);
    endtask

    // Observe the SETTLE/EMIT window; z_in is only correct during the
    // cycle whose closing edge should sample it
    task automatic capture_result(input logic [NIN-1:0] v, output int lat,
                                  output logic [TAG_W+NOUT-1:0] data,
                                  output bit hold_ok);
        lat = 0; hold_ok = 1'b1;
        for (int k = 1; k <= int'(SETTLE) + 20; k++) begin
            if (m_valid === 1'b1) begin
                lat = k;
                break;
            end
            if (x_out !== v || s_ready !== 1'b0) hold_ok = 1'b0;
            z_drv = (k == int'(SETTLE)) ? pla_model(v) : ~pla_model(v);
            @(negedge clk);
        end
        data = m_data;
        if (x_out !== v || s_ready !== 1'b0) hold_ok = 1'b0;
    endtask

    task automatic release_result();
        m_ready_drv = 1'b1;
        @(negedge clk);
        m_ready_drv = 1'b0;
        exp_tag = (exp_tag + 1) % 256;
    endtask

    // Reference model over a beat stream: complete vectors and framing errors
    task automatic model_stream();
        logic [NIN-1:0] cur;
        int n;
        cur = '0; n = 0;
        foreach (stim_q[i]) begin
            if (stim_q[i].f) begin
                if (n != 0) exp_err = (exp_err < 255) ? exp_err + 1 : 255;
                cur = '0; cur[0] = stim_q[i].d; n = 1;
            end else if (n == 0) begin
                exp_err = (exp_err < 255) ? exp_err + 1 : 255;
            end else begin
                cur[n] = stim_q[i].d; n++;
                if (n == int'(NIN)) begin
                    exp_vec_q.push_back(cur);
                    n = 0;
                end
            end
        end
    endtask

    task automatic drain(input int want);
        int n;
        n = 0;
        while (got_q.size() < want && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        s_valid = 1'b1; s_data = 1'b1; s_first = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++; if (x_out !== '0) $display("FAIL reset_x_out: got %h want 0", x_out); else n_pass++;
        n_chk++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b want 0", m_valid); else n_pass++;
        n_chk++; if (m_data !== '0) $display("FAIL reset_m_data: got %h want 0", m_data); else n_pass++;
        n_chk++; if (err_cnt !== 8'd0) $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); else n_pass++;
        n_chk++; if (s_ready !== 1'b1) $display("FAIL reset_s_ready: got %b want 1", s_ready); else n_pass++;
        s_valid = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++; if (err_cnt !== 8'd0) $display("FAIL reset_no_accept: err_cnt %0d want 0", err_cnt); else n_pass++;
    endtask

    task automatic test_all_ones();
        logic [NIN-1:0] v;
        logic [TAG_W+NOUT-1:0] d;
        int lat; bit ok;
        v = '1;
        send_bits(v, 26);
        n_chk++; if (x_out !== '0) $display("FAIL ones_x_early: got %h want 0", x_out); else n_pass++;
        send_beat(v[26], 1'b0);
        n_chk++; if (x_out !== v) $display("FAIL ones_x_new: got %h want %h", x_out, v); else n_pass++;
        capture_result(v, lat, d, ok);
        n_chk++; if (lat != int'(SETTLE) + 1) $display("FAIL ones_latency: got %0d want %0d", lat, SETTLE + 1); else n_pass++;
        n_chk++; if (d !== {8'(exp_tag), pla_model(v)}) $display("FAIL ones_m_data: got %h want %h", d, {8'(exp_tag), pla_model(v)}); else n_pass++;
        n_chk++; if (!ok) $display("FAIL ones_hold: x_out/s_ready not held during settle (x=%h s_ready=%b)", x_out, s_ready); else n_pass++;
        release_result();
        n_chk++; if (m_valid !== 1'b0 || s_ready !== 1'b1) $display("FAIL ones_release: m_valid=%b s_ready=%b want 0/1", m_valid, s_ready); else n_pass++;
    endtask

    task automatic test_single_bit();
        logic [NIN-1:0] v;
        logic [TAG_W+NOUT-1:0] d;
        int lat; bit ok;
        v = '0; v[5] = 1'b1;
        send_bits(v, 27);
        capture_result(v, lat, d, ok);
        n_chk++; if (d !== {8'(exp_tag), pla_model(v)}) $display("FAIL x05_m_data: got %h want %h", d, {8'(exp_tag), pla_model(v)}); else n_pass++;
        n_chk++; if (err_cnt !== 8'(exp_err)) $display("FAIL x05_err_cnt: got %0d want %0d", err_cnt, exp_err); else n_pass++;
        release_result();
    endtask

    task automatic test_backpressure();
        logic [NIN-1:0] v;
        logic [TAG_W+NOUT-1:0] d;
        int lat; bit ok, stable;
        v = 27'($urandom);
        send_bits(v, 27);
        capture_result(v, lat, d, ok);
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (m_valid !== 1'b1 || m_data !== d || x_out !== v || s_ready !== 1'b0) stable = 1'b0;
            @(negedge clk);
        end
        n_chk++; if (!stable) $display("FAIL bp_stable: m_valid=%b m_data=%h x_out=%h s_ready=%b", m_valid, m_data, x_out, s_ready); else n_pass++;
        n_chk++; if (d !== {8'(exp_tag), pla_model(v)}) $display("FAIL bp_m_data: got %h want %h", d, {8'(exp_tag), pla_model(v)}); else n_pass++;
        release_result();
        n_chk++; if (m_valid !== 1'b0) $display("FAIL bp_release: m_valid %b want 0", m_valid); else n_pass++;
    endtask

    task automatic test_resync();
        logic [NIN-1:0] a, b;
        logic [TAG_W+NOUT-1:0] d;
        int lat; bit ok;
        a = 27'($urandom); b = 27'($urandom);
        send_bits(a, 10);
        send_bits(b, 27);
        exp_err++;
        capture_result(b, lat, d, ok);
        n_chk++; if (err_cnt !== 8'(exp_err)) $display("FAIL resync_err_cnt: got %0d want %0d", err_cnt, exp_err); else n_pass++;
        n_chk++; if (x_out !== b) $display("FAIL resync_x_out: got %h want %h", x_out, b); else n_pass++;
        n_chk++; if (d !== {8'(exp_tag), pla_model(b)}) $display("FAIL resync_m_data: got %h want %h", d, {8'(exp_tag), pla_model(b)}); else n_pass++;
        release_result();
    endtask

    task automatic test_stray();
        logic [NIN-1:0] v;
        logic [TAG_W+NOUT-1:0] d;
        int lat; bit ok;
        v = 27'($urandom);
        send_beat(1'($urandom_range(0, 1)), 1'b0);
        exp_err++;
        send_bits(v, 27);
        capture_result(v, lat, d, ok);
        n_chk++; if (err_cnt !== 8'(exp_err)) $display("FAIL stray_err_cnt: got %0d want %0d", err_cnt, exp_err); else n_pass++;
        n_chk++; if (d !== {8'(exp_tag), pla_model(v)}) $display("FAIL stray_m_data: got %h want %h", d, {8'(exp_tag), pla_model(v)}); else n_pass++;
        release_result();
    endtask

    task automatic test_reset_in_settle();
        logic [NIN-1:0] v;
        bit quiet;
        v = 27'($urandom) | 27'd1;
        send_bits(v, 27);
        rst_n = 1'b0;
        #1;
        n_chk++; if (x_out !== '0) $display("FAIL rst_settle_x_out: got %h want 0", x_out); else n_pass++;
        n_chk++; if (m_valid !== 1'b0) $display("FAIL rst_settle_m_valid: got %b want 0", m_valid); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        exp_err = 0; exp_tag = 0;
        quiet = 1'b1;
        for (int i = 0; i < int'(SETTLE) + 4; i++) begin
            if (m_valid !== 1'b0 || s_ready !== 1'b1) quiet = 1'b0;
            @(negedge clk);
        end
        n_chk++; if (!quiet) $display("FAIL rst_settle_no_emit: m_valid=%b s_ready=%b want 0/1", m_valid, s_ready); else n_pass++;
    endtask

    task automatic test_tag_wrap();
        logic [NIN-1:0] v;
        logic [TAG_W+NOUT-1:0] want;
        int nbad;
        z_from_x = 1'b1; rand_ready = 1'b0; got_q.delete(); exp_vec_q.delete();
        mon_en = 1'b1;
        for (int i = 0; i < 257; i++) begin
            v = 27'($urandom);
            exp_vec_q.push_back(v);
            send_bits(v, 27);
        end
        drain(257);
        mon_en = 1'b0;
        n_chk++; if (got_q.size() != 257) $display("FAIL wrap_count: got %0d results want 257", got_q.size()); else n_pass++;
        nbad = 0;
        for (int i = 0; i < 257 && i < got_q.size(); i++) begin
            want = {8'(i % 256), pla_model(exp_vec_q[i])};
            if (got_q[i] !== want) begin
                if (nbad < 4) $display("FAIL wrap_result[%0d]: got %h want %h", i, got_q[i], want);
                nbad++;
            end
        end
        n_chk++; if (nbad == 0) n_pass++; else $display("FAIL wrap_results: %0d wrong results, want 0", nbad);
        n_chk++; if (got_q.size() == 257 && got_q[256][13:6] !== 8'h00) $display("FAIL wrap_last_tag: got %h want 00", got_q[256][13:6]); else n_pass++;
        exp_tag = 257 % 256;
    endtask

    task automatic test_random_stream();
        logic [NIN-1:0] v;
        logic [TAG_W+NOUT-1:0] want;
        int r, k, nbad, tag0;
        stim_q.delete(); exp_vec_q.delete(); got_q.delete();
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 5);
            if (r == 0) stim_q.push_back('{d: 1'($urandom), f: 1'b0});
            if (r == 1) begin
                k = $urandom_range(1, 25);
                for (int j = 0; j < k; j++) stim_q.push_back('{d: 1'($urandom), f: (j == 0)});
            end
            v = 27'($urandom);
            for (int j = 0; j < int'(NIN); j++) stim_q.push_back('{d: v[j], f: (j == 0)});
        end
        model_stream();
        tag0 = exp_tag;
        z_from_x = 1'b1; rand_ready = 1'b1;
        mon_en = 1'b1;
        foreach (stim_q[i]) send_beat(stim_q[i].d, stim_q[i].f);
        drain(exp_vec_q.size());
        while (m_valid === 1'b1) @(negedge clk);
        mon_en = 1'b0;
        n_chk++; if (got_q.size() != exp_vec_q.size()) $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_vec_q.size()); else n_pass++;
        nbad = 0;
        for (int i = 0; i < exp_vec_q.size() && i < got_q.size(); i++) begin
            want = {8'((tag0 + i) % 256), pla_model(exp_vec_q[i])};
            if (got_q[i] !== want) begin
                if (nbad < 4) $display("FAIL rand_result[%0d]: got %h want %h", i, got_q[i], want);
                nbad++;
            end
        end
        n_chk++; if (nbad == 0) n_pass++; else $display("FAIL rand_results: %0d wrong results, want 0", nbad);
        n_chk++; if (err_cnt !== 8'(exp_err)) $display("FAIL rand_err_cnt: got %0d want %0d", err_cnt, exp_err); else n_pass++;
        exp_tag = (tag0 + got_q.size()) % 256;
    endtask

    task automatic test_err_saturate();
        int need;
        need = 254 - exp_err;
        for (int i = 0; i < need; i++) send_beat(1'b0, 1'b0);
        exp_err = 254;
        n_chk++; if (err_cnt !== 8'd254) $display("FAIL sat_254: got %0d want 254", err_cnt); else n_pass++;
        for (int i = 0; i < 3; i++) send_beat(1'b1, 1'b0);
        exp_err = 255;
        n_chk++; if (err_cnt !== 8'd255) $display("FAIL sat_255: got %0d want 255", err_cnt); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_single_bit();
        test_backpressure();
        test_resync();
        test_stray();
        test_reset_in_settle();
        test_tag_wrap();
        test_random_stream();
        test_err_saturate();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
